// File: rtl/wb_regfile.sv
// Eight-entry 16-bit register file with writeback bypass, load-use scoreboard
// and a counter of retired register writes.
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_reg_write,
  input  logic        wb_mem_to_reg,
  input  logic [2:0]  wb_rd,
  input  logic [15:0] wb_alu_result,
  input  logic [15:0] wb_mem_data,
  input  logic [2:0]  rs_addr,
  input  logic [2:0]  rt_addr,
  input  logic        rs_used,
  input  logic        rt_used,
  output logic [15:0] rs_data,
  output logic [15:0] rt_data,
  input  logic        ld_issue,
  input  logic [2:0]  ld_rd,
  output logic        stall,
  output logic [7:0]  busy,
  output logic [15:0] wb_data,
  output logic [15:0] retire_cnt
);

  logic [7:0][15:0] regs_q, regs_d;
  logic [7:0]       busy_q, busy_d;
  logic [15:0]      retire_q, retire_d;

  logic commit;
  logic ldClear;
  logic ldSet;
  logic rsStall;
  logic rtStall;

  // A commit or load issue coincident with reset is discarded, so both are
  // gated by rst; this also keeps the read bypass quiet while in reset.
  always_comb begin
    wb_data = wb_mem_to_reg ? wb_mem_data : wb_alu_result;
    commit  = wb_reg_write && (wb_rd != 3'd0) && !rst;
    ldClear = commit && wb_mem_to_reg;
    rsStall = rs_used && busy_q[rs_addr] && !(ldClear && (wb_rd == rs_addr));
    rtStall = rt_used && busy_q[rt_addr] && !(ldClear && (wb_rd == rt_addr));
    stall   = rsStall || rtStall;
    ldSet   = ld_issue && (ld_rd != 3'd0) && !stall && !rst;
  end

  always_comb begin
    rs_data = regs_q[rs_addr];
    rt_data = regs_q[rt_addr];
    if (commit && (wb_rd == rs_addr)) begin
      rs_data = wb_data;
    end
    if (commit && (wb_rd == rt_addr)) begin
      rt_data = wb_data;
    end
  end

  // Set is applied after clear so a same-index set/clear leaves the bit set.
  always_comb begin
    regs_d   = regs_q;
    busy_d   = busy_q;
    retire_d = retire_q;
    if (commit) begin
      regs_d[wb_rd] = wb_data;
      retire_d      = retire_q + 16'd1;
    end
    if (ldClear) begin
      busy_d[wb_rd] = 1'b0;
    end
    if (ldSet) begin
      busy_d[ld_rd] = 1'b1;
    end
    regs_d[0] = 16'h0000;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q   <= '0;
      busy_q   <= '0;
      retire_q <= '0;
    end else begin
      regs_q   <= regs_d;
      busy_q   <= busy_d;
      retire_q <= retire_d;
    end
  end

  assign busy       = busy_q;
  assign retire_cnt = retire_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: reset, write/bypass, load-use
// stall, R0 handling, set/clear priority, counter wrap and async reset.
`timescale 1ns/1ps
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_reg_write;
  logic        wb_mem_to_reg;
  logic [2:0]  wb_rd;
  logic [15:0] wb_alu_result;
  logic [15:0] wb_mem_data;
  logic [2:0]  rs_addr;
  logic [2:0]  rt_addr;
  logic        rs_used;
  logic        rt_used;
  logic [15:0] rs_data;
  logic [15:0] rt_data;
  logic        ld_issue;
  logic [2:0]  ld_rd;
  logic        stall;
  logic [7:0]  busy;
  logic [15:0] wb_data;
  logic [15:0] retire_cnt;

  int compared = 0;
  int mismatched = 0;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd),
    .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used), .rt_used(rt_used),
    .rs_data(rs_data), .rt_data(rt_data),
    .ld_issue(ld_issue), .ld_rd(ld_rd),
    .stall(stall), .busy(busy), .wb_data(wb_data), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic idle();
    wb_reg_write = 1'b0; wb_mem_to_reg = 1'b0; wb_rd = 3'd0;
    wb_alu_result = 16'h0000; wb_mem_data = 16'h0000;
    rs_addr = 3'd0; rt_addr = 3'd0; rs_used = 1'b0; rt_used = 1'b0;
    ld_issue = 1'b0; ld_rd = 3'd0;
  endtask

  // Advance one edge and settle 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    step();
    for (int i = 0; i < 8; i++) begin
      rs_addr = 3'(i); rt_addr = 3'(7 - i);
      #1;
      compared++;
      if (rs_data !== 16'h0000 || rt_data !== 16'h0000) begin
        mismatched++;
        $display("[TB] FAIL reset_read[%0d]: got rs=%h rt=%h want 0000", i, rs_data, rt_data);
      end
    end
    compared++;
    if (busy !== 8'h00 || retire_cnt !== 16'h0000 || stall !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_state: got busy=%h cnt=%h stall=%b want 00/0000/0", busy, retire_cnt, stall);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_write_bypass();
    idle();
    wb_reg_write = 1'b1; wb_rd = 3'd3; wb_alu_result = 16'h1234; wb_mem_data = 16'h5555;
    rs_addr = 3'd3; rt_addr = 3'd3;
    #1;
    compared++;
    if (wb_data !== 16'h1234) begin mismatched++; $display("[TB] FAIL wb_data_alu: got %h want 1234", wb_data); end
    compared++;
    if (rs_data !== 16'h1234 || rt_data !== 16'h1234) begin
      mismatched++; $display("[TB] FAIL bypass_r3: got rs=%h rt=%h want 1234", rs_data, rt_data);
    end
    step();
    wb_reg_write = 1'b0; wb_mem_to_reg = 1'b1; wb_mem_data = 16'hA5A5; wb_alu_result = 16'h0BAD;
    #1;
    compared++;
    if (rs_data !== 16'h1234) begin mismatched++; $display("[TB] FAIL read_r3: got %h want 1234", rs_data); end
    compared++;
    if (wb_data !== 16'hA5A5) begin mismatched++; $display("[TB] FAIL wb_data_mem_nowrite: got %h want a5a5", wb_data); end
    compared++;
    if (retire_cnt !== 16'd1) begin mismatched++; $display("[TB] FAIL retire_after_write: got %0d want 1", retire_cnt); end
    step();
    compared++;
    if (rs_data !== 16'h1234 || retire_cnt !== 16'd1) begin
      mismatched++; $display("[TB] FAIL no_write_when_disabled: got r3=%h cnt=%0d want 1234/1", rs_data, retire_cnt);
    end
  endtask

  task automatic test_load_stall();
    idle();
    ld_issue = 1'b1; ld_rd = 3'd5;
    step();
    ld_issue = 1'b0;
    rs_used = 1'b1; rs_addr = 3'd5;
    #1;
    compared++;
    if (busy !== 8'h20 || stall !== 1'b1) begin
      mismatched++; $display("[TB] FAIL load_busy_stall_rs: got busy=%h stall=%b want 20/1", busy, stall);
    end
    step();
    rs_used = 1'b0; rt_used = 1'b1; rt_addr = 3'd5;
    ld_issue = 1'b1; ld_rd = 3'd6;
    #1;
    compared++;
    if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_rt: got %b want 1", stall); end
    step();
    idle();
    compared++;
    if (busy !== 8'h20) begin mismatched++; $display("[TB] FAIL ld_ignored_when_stalled: got busy=%h want 20", busy); end
    rs_used = 1'b1; rs_addr = 3'd5;
    wb_reg_write = 1'b1; wb_mem_to_reg = 1'b1; wb_rd = 3'd5;
    wb_mem_data = 16'hBEEF; wb_alu_result = 16'h0F0F;
    #1;
    compared++;
    if (stall !== 1'b0 || rs_data !== 16'hBEEF) begin
      mismatched++; $display("[TB] FAIL wb_load_release: got stall=%b rs=%h want 0/beef", stall, rs_data);
    end
    step();
    idle();
    rs_addr = 3'd5;
    #1;
    compared++;
    if (busy !== 8'h00 || retire_cnt !== 16'd2 || rs_data !== 16'hBEEF) begin
      mismatched++; $display("[TB] FAIL after_wb_load: got busy=%h cnt=%0d r5=%h want 00/2/beef", busy, retire_cnt, rs_data);
    end
  endtask

  task automatic test_r0();
    idle();
    wb_reg_write = 1'b1; wb_rd = 3'd0; wb_alu_result = 16'hFFFF;
    rs_addr = 3'd0;
    #1;
    compared++;
    if (rs_data !== 16'h0000) begin mismatched++; $display("[TB] FAIL r0_no_bypass: got %h want 0000", rs_data); end
    step();
    wb_reg_write = 1'b0;
    ld_issue = 1'b1; ld_rd = 3'd0;
    #1;
    compared++;
    if (rs_data !== 16'h0000 || retire_cnt !== 16'd2) begin
      mismatched++; $display("[TB] FAIL r0_write: got r0=%h cnt=%0d want 0000/2", rs_data, retire_cnt);
    end
    step();
    idle();
    compared++;
    if (busy !== 8'h00) begin mismatched++; $display("[TB] FAIL r0_ld_issue: got busy=%h want 00", busy); end
  endtask

  task automatic test_set_clear_same();
    idle();
    ld_issue = 1'b1; ld_rd = 3'd2;
    step();
    wb_reg_write = 1'b1; wb_mem_to_reg = 1'b1; wb_rd = 3'd2; wb_mem_data = 16'h00AA;
    step();
    idle();
    rs_addr = 3'd2;
    #1;
    compared++;
    if (busy !== 8'h04 || rs_data !== 16'h00AA || retire_cnt !== 16'd3) begin
      mismatched++; $display("[TB] FAIL set_wins: got busy=%h r2=%h cnt=%0d want 04/00aa/3", busy, rs_data, retire_cnt);
    end
    wb_reg_write = 1'b1; wb_mem_to_reg = 1'b0; wb_rd = 3'd2; wb_alu_result = 16'h0011;
    step();
    compared++;
    if (busy !== 8'h04 || retire_cnt !== 16'd4) begin
      mismatched++; $display("[TB] FAIL alu_no_clear: got busy=%h cnt=%0d want 04/4", busy, retire_cnt);
    end
    wb_mem_to_reg = 1'b1; wb_mem_data = 16'h0022;
    step();
    idle();
    rs_addr = 3'd2;
    #1;
    compared++;
    if (busy !== 8'h00 || rs_data !== 16'h0022 || retire_cnt !== 16'd5) begin
      mismatched++; $display("[TB] FAIL load_clear: got busy=%h r2=%h cnt=%0d want 00/0022/5", busy, rs_data, retire_cnt);
    end
  endtask

  task automatic test_wrap_and_reset();
    idle();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    step();
    wb_reg_write = 1'b1; wb_rd = 3'd1;
    for (int i = 0; i < 65535; i++) begin
      wb_alu_result = 16'(i);
      step();
    end
    wb_reg_write = 1'b0; rs_addr = 3'd1;
    #1;
    compared++;
    if (retire_cnt !== 16'hFFFF || rs_data !== 16'hFFFE) begin
      mismatched++; $display("[TB] FAIL preload: got cnt=%h r1=%h want ffff/fffe", retire_cnt, rs_data);
    end
    wb_reg_write = 1'b1; wb_alu_result = 16'h7777;
    step();
    compared++;
    if (retire_cnt !== 16'h0000) begin mismatched++; $display("[TB] FAIL wrap: got %h want 0000", retire_cnt); end
    wb_alu_result = 16'h4321;
    ld_issue = 1'b1; ld_rd = 3'd7;
    step();
    ld_issue = 1'b0; wb_rd = 3'd4; wb_alu_result = 16'h9999;
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if (retire_cnt !== 16'h0000 || busy !== 8'h00 || rs_data !== 16'h0000 || stall !== 1'b0) begin
      mismatched++; $display("[TB] FAIL async_reset: got cnt=%h busy=%h r1=%h stall=%b want 0000/00/0000/0", retire_cnt, busy, rs_data, stall);
    end
    ld_issue = 1'b1; ld_rd = 3'd3;
    step();
    rs_addr = 3'd4;
    #1;
    compared++;
    if (rs_data !== 16'h0000 || retire_cnt !== 16'h0000 || busy !== 8'h00) begin
      mismatched++; $display("[TB] FAIL reset_discard: got r4=%h cnt=%h busy=%h want 0000/0000/00", rs_data, retire_cnt, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    idle();
    wb_reg_write = 1'b1; wb_rd = 3'd6; wb_alu_result = 16'h0C0C;
    step();
    idle();
    rs_addr = 3'd6;
    #1;
    compared++;
    if (rs_data !== 16'h0C0C || retire_cnt !== 16'd1) begin
      mismatched++; $display("[TB] FAIL resume: got r6=%h cnt=%0d want 0c0c/1", rs_data, retire_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_load_stall();
    test_r0();
    test_set_clear_same();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have port clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port wb_reg_write  input  1  writeback enable from the MEM/WB register.
REQ-004 SHALL have port wb_mem_to_reg  input  1  1 selects wb_mem_data as write data, 0 selects wb_alu_result.
REQ-005 SHALL have port wb_rd  input  3  destination register index.
REQ-006 SHALL have port wb_alu_result  input  16  ALU result from MEM/WB.
REQ-007 SHALL have port wb_mem_data  input  16  load data from MEM/WB.
REQ-008 SHALL have ports rs_addr and rt_addr  input  3 each  decode-stage read indices.
REQ-009 SHALL have ports rs_used and rt_used  input  1 each  decode instruction actually reads that operand.
REQ-010 SHALL have ports rs_data and rt_data  output  16 each  read data, combinational.
REQ-011 SHALL have port ld_issue  input  1  a load leaves decode this cycle.
REQ-012 SHALL have port ld_rd  input  3  destination index of the issuing load.
REQ-013 SHALL have port stall  output  1  decode must hold, combinational.
REQ-014 SHALL have port busy  output  8  scoreboard bit per register, registered.
REQ-015 SHALL have port wb_data  output  16  selected write data, combinational, for forwarding.
REQ-016 SHALL have port retire_cnt  output  16  count of committed register writes, registered.

Function
REQ-017 SHALL hold 8 registers of 16 bits; R0 SHALL always read 0 and SHALL never be written.
REQ-018 SHALL drive wb_data as wb_mem_data when wb_mem_to_reg=1, else wb_alu_result, independent of wb_reg_write.
REQ-019 SHALL commit a write when wb_reg_write=1 and wb_rd!=0, writing wb_data to register wb_rd at the rising edge.
REQ-020 SHALL bypass: while a write commits in the same cycle, a read of index wb_rd (nonzero) SHALL return wb_data, not the stale value.
REQ-021 SHALL set busy[ld_rd] at the edge when ld_issue=1 and ld_rd!=0; busy[0] SHALL stay 0.
REQ-022 SHALL clear busy[wb_rd] at the edge when wb_reg_write=1, wb_mem_to_reg=1 and wb_rd!=0.
REQ-023 SHALL keep busy set when a set and a clear target the same index in one cycle, because set wins.
REQ-024 SHALL assert stall when (rs_used and busy[rs_addr] and not clearing rs_addr this cycle) or the same condition holds for rt.
REQ-025 SHALL NOT let ld_issue take effect while stall=1: a set with stall=1 SHALL be ignored.
REQ-026 SHALL increment retire_cnt by 1 on each committed write, wrapping from 0xFFFF to 0x0000.
REQ-027 SHALL NOT change any register, busy bit or retire_cnt on a write to R0 or when wb_reg_write=0.

Reset
REQ-028 SHALL clear, asynchronously on rst=1, all registers, busy and retire_cnt to 0; stall then SHALL read 0.
REQ-029 SHALL discard a write or ld_issue coincident with rst; normal operation SHALL resume on the first edge after rst falls.

Verification
REQ-030 Reset then read all eight indices -> every rs_data and rt_data is 0x0000, busy=0x00, retire_cnt=0.
REQ-031 Write R3=0x1234 (alu path), then read R3 next cycle -> 0x1234; same-cycle read of R3 during the write -> 0x1234 via bypass.
REQ-032 ld_issue with ld_rd=5, then decode reads rs=5 with rs_used=1 -> stall=1 until the WB load to R5 with mem_data=0xBEEF, in which cycle stall=0 and rs_data=0xBEEF.
REQ-033 Write to R0 with data 0xFFFF -> R0 reads 0, retire_cnt unchanged; ld_issue with ld_rd=0 -> busy unchanged.
REQ-034 Same cycle: WB load clears R2 and ld_issue sets R2 -> busy[2]=1 afterwards.
REQ-035 Preload retire_cnt to 0xFFFF by 65535 writes, then one more write -> retire_cnt=0x0000; assert rst mid-sequence -> all state 0 immediately.
